// File: rtl/gb_bus_pkg.sv
// Shared encodings for the external memory bus: owner codes, T-phase numbers
// and default bus widths.
package gb_bus_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 8;

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_CPU  = 2'd1;
   localparam logic [1:0] OWN_DMA  = 2'd2;

   localparam logic [1:0] T1 = 2'd0;
   localparam logic [1:0] T2 = 2'd1;
   localparam logic [1:0] T3 = 2'd2;
   localparam logic [1:0] T4 = 2'd3;

   // Width of the DMA run counter; at least one bit so the strict-priority
   // build (max_run == 0) still has a legal vector.
   function automatic int run_w(input int max_run);
      return (max_run < 2) ? 1 : $clog2(max_run + 1);
   endfunction

endpackage

// File: rtl/bus_arb_pick.sv
// Priority/fairness selector: decides who owns the next M-cycle from the
// sampled requests and the current DMA run length.
module bus_arb_pick
   import gb_bus_pkg::*;
#(
   parameter int MAX_DMA_RUN = 4,
   parameter int RUN_W       = 3
) (
   input  logic             cpu_req,
   input  logic             dma_req,
   input  logic [RUN_W-1:0] run_cnt,
   output logic [1:0]       next_owner
);

   logic run_full;

   assign run_full = (MAX_DMA_RUN != 0) && (run_cnt == RUN_W'(MAX_DMA_RUN));

   // NOTE: every output of a combinational block gets a default first so no
   // path leaves it unassigned and a latch cannot be inferred.
   always_comb begin
      next_owner = OWN_NONE;
      if (cpu_req && dma_req) begin
         next_owner = run_full ? OWN_CPU : OWN_DMA;
      end else if (cpu_req) begin
         next_owner = OWN_CPU;
      end else if (dma_req) begin
         next_owner = OWN_DMA;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Owns the external memory bus: free-running T1..T4 phase, CPU/DMA arbitration
// at each M-cycle boundary, request latching and per-phase strobe generation.
module mem_bus_arbiter
   import gb_bus_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int MAX_DMA_RUN = 4
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_wait,

   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_ack,
   output logic [DATA_W-1:0] dma_rdata,

   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic              mem_oe,

   output logic [1:0]        t_cycle,
   output logic [1:0]        owner
);

   localparam int RUN_W = run_w(MAX_DMA_RUN);

   logic [1:0]        t_q;
   logic [1:0]        owner_q;
   logic [RUN_W-1:0]  run_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic [DATA_W-1:0] cpu_rdata_q;
   logic [DATA_W-1:0] dma_rdata_q;

   logic [1:0]        next_owner;
   logic [RUN_W-1:0]  next_run;
   logic              owned;
   logic              data_phase;

   bus_arb_pick #(
      .MAX_DMA_RUN (MAX_DMA_RUN),
      .RUN_W       (RUN_W)
   ) u_pick (
      .cpu_req    (cpu_req),
      .dma_req    (dma_req),
      .run_cnt    (run_q),
      .next_owner (next_owner)
   );

   // Run length only grows while the CPU is actually being held off.
   always_comb begin
      next_run = '0;
      if (next_owner == OWN_DMA && cpu_req) begin
         next_run = (run_q == RUN_W'(MAX_DMA_RUN)) ? run_q : run_q + 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         t_q         <= T1;
         owner_q     <= OWN_NONE;
         run_q       <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         mem_wdata_q <= '0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
      end else begin
         t_q <= t_q + 2'd1;

         if (t_q == T1 && owner_q != OWN_NONE && we_q) begin
            mem_wdata_q <= wdata_q;
         end

         if (t_q == T3 && !we_q) begin
            if (owner_q == OWN_CPU) cpu_rdata_q <= mem_rdata;
            if (owner_q == OWN_DMA) dma_rdata_q <= mem_rdata;
         end

         if (t_q == T4) begin
            owner_q <= next_owner;
            run_q   <= next_run;
            if (next_owner == OWN_CPU) begin
               addr_q  <= cpu_addr;
               we_q    <= cpu_we;
               wdata_q <= cpu_wdata;
            end else if (next_owner == OWN_DMA) begin
               addr_q  <= dma_addr;
               we_q    <= dma_we;
               wdata_q <= dma_wdata;
            end
         end
      end
   end

   assign owned      = (owner_q != OWN_NONE);
   assign data_phase = (t_q == T2) || (t_q == T3);

   // Strobes decode straight from flops so an async reset drops them at once.
   assign mem_rd    = owned && !we_q && data_phase;
   assign mem_oe    = owned &&  we_q && data_phase;
   assign mem_wr    = owned &&  we_q && (t_q == T3);
   assign mem_addr  = addr_q;
   assign mem_wdata = mem_wdata_q;

   assign cpu_ack   = (owner_q == OWN_CPU) && (t_q == T4);
   assign dma_ack   = (owner_q == OWN_DMA) && (t_q == T4);
   assign cpu_rdata = cpu_rdata_q;
   assign dma_rdata = dma_rdata_q;
   assign cpu_wait  = rst && cpu_req && (owner_q != OWN_CPU);

   assign t_cycle = t_q;
   assign owner   = owner_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Drives a fairness build (run limit 4) and a strict-priority build (limit 0)
// with shared stimulus and compares both against a transaction-level model.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we, dma_req, dma_we;
   logic [15:0] cpu_addr, dma_addr;
   logic [7:0]  cpu_wdata, dma_wdata, mem_rdata;

   logic [1:0]  cpu_ack_o, dma_ack_o, cpu_wait_o, mem_rd_o, mem_wr_o, mem_oe_o;
   logic [7:0]  cpu_rdata_o [2];
   logic [7:0]  dma_rdata_o [2];
   logic [15:0] mem_addr_o  [2];
   logic [7:0]  mem_wdata_o [2];
   logic [1:0]  t_cycle_o   [2];
   logic [1:0]  owner_o     [2];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      mem_bus_arbiter #(
         .ADDR_W      (16),
         .DATA_W      (8),
         .MAX_DMA_RUN (g == 0 ? 4 : 0)
      ) dut (
         .clk       (clk),
         .rst       (rst),
         .cpu_req   (cpu_req),
         .cpu_we    (cpu_we),
         .cpu_addr  (cpu_addr),
         .cpu_wdata (cpu_wdata),
         .cpu_ack   (cpu_ack_o[g]),
         .cpu_rdata (cpu_rdata_o[g]),
         .cpu_wait  (cpu_wait_o[g]),
         .dma_req   (dma_req),
         .dma_we    (dma_we),
         .dma_addr  (dma_addr),
         .dma_wdata (dma_wdata),
         .dma_ack   (dma_ack_o[g]),
         .dma_rdata (dma_rdata_o[g]),
         .mem_addr  (mem_addr_o[g]),
         .mem_wdata (mem_wdata_o[g]),
         .mem_rdata (mem_rdata),
         .mem_rd    (mem_rd_o[g]),
         .mem_wr    (mem_wr_o[g]),
         .mem_oe    (mem_oe_o[g]),
         .t_cycle   (t_cycle_o[g]),
         .owner     (owner_o[g])
      );
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      else n_pass++;
   endtask

   // Reference model: one transaction record per M-cycle per build.
   int          max_run [2] = '{4, 0};
   int          cyc;
   logic [1:0]  m_owner [2];
   int          m_run   [2];
   logic        m_we    [2];
   logic [15:0] m_addr  [2];
   logic [7:0]  m_wdata [2];
   logic [7:0]  m_crd   [2];
   logic [7:0]  m_drd   [2];

   task automatic model_reset();
      cyc = 0;
      for (int i = 0; i < 2; i++) begin
         m_owner[i] = 2'd0; m_run[i] = 0; m_we[i] = 1'b0;
         m_addr[i] = '0; m_wdata[i] = '0; m_crd[i] = '0; m_drd[i] = '0;
      end
   endtask

   task automatic model_step();
      int t;
      t = cyc % 4;
      for (int i = 0; i < 2; i++) begin
         if (t == 2 && !m_we[i]) begin
            if (m_owner[i] == 2'd1) m_crd[i] = mem_rdata;
            if (m_owner[i] == 2'd2) m_drd[i] = mem_rdata;
         end
         if (t == 3) begin
            logic [1:0] win;
            if (cpu_req && dma_req)
               win = (max_run[i] != 0 && m_run[i] == max_run[i]) ? 2'd1 : 2'd2;
            else if (cpu_req) win = 2'd1;
            else if (dma_req) win = 2'd2;
            else win = 2'd0;
            if (win == 2'd2 && cpu_req)
               m_run[i] = (m_run[i] + 1 > max_run[i]) ? max_run[i] : m_run[i] + 1;
            else
               m_run[i] = 0;
            m_owner[i] = win;
            if (win == 2'd1) begin
               m_addr[i] = cpu_addr; m_we[i] = cpu_we; m_wdata[i] = cpu_wdata;
            end else if (win == 2'd2) begin
               m_addr[i] = dma_addr; m_we[i] = dma_we; m_wdata[i] = dma_wdata;
            end
         end
      end
      cyc++;
   endtask

   function automatic logic exp_ack(input int i, input logic [1:0] who);
      return (m_owner[i] == who) && (cyc % 4 == 3);
   endfunction

   task automatic check_dut(input int i);
      int   t;
      logic own, mid;
      t   = cyc % 4;
      own = (m_owner[i] != 2'd0);
      mid = (t == 1 || t == 2);
      check($sformatf("d%0d_t_cycle", i), t_cycle_o[i], t);
      check($sformatf("d%0d_owner", i), owner_o[i], m_owner[i]);
      check($sformatf("d%0d_mem_rd", i), mem_rd_o[i], own && !m_we[i] && mid);
      check($sformatf("d%0d_mem_oe", i), mem_oe_o[i], own && m_we[i] && mid);
      check($sformatf("d%0d_mem_wr", i), mem_wr_o[i], own && m_we[i] && t == 2);
      check($sformatf("d%0d_mem_addr", i), mem_addr_o[i], m_addr[i]);
      if (own && m_we[i] && mid)
         check($sformatf("d%0d_mem_wdata", i), mem_wdata_o[i], m_wdata[i]);
      check($sformatf("d%0d_cpu_ack", i), cpu_ack_o[i], exp_ack(i, 2'd1));
      check($sformatf("d%0d_dma_ack", i), dma_ack_o[i], exp_ack(i, 2'd2));
      check($sformatf("d%0d_cpu_rdata", i), cpu_rdata_o[i], m_crd[i]);
      check($sformatf("d%0d_dma_rdata", i), dma_rdata_o[i], m_drd[i]);
      check($sformatf("d%0d_cpu_wait", i), cpu_wait_o[i],
            rst && cpu_req && m_owner[i] != 2'd1);
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_step();
      @(negedge clk);
      check_dut(0);
      check_dut(1);
   endtask

   task automatic to_t4();
      for (int k = 0; k < 4 && cyc % 4 != 3; k++) tick();
   endtask

   int n_own, n_wr, n_rd, n_cack, n_dack;
   logic got;
   logic [1:0] exp_seq [10] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

   initial begin
      rst = 1'b0;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
      mem_rdata = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check_dut(0);
      check_dut(1);
      rst = 1'b1;

      // CPU read alone
      to_t4();
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'hC000; mem_rdata = 8'h5A;
      n_own = 0; n_rd = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (owner_o[0] == 2'd1) n_own++;
         if (mem_rd_o[0]) n_rd++;
         if (exp_ack(0, 2'd1)) cpu_req = 0;
      end
      check("rd_owner_clks", n_own, 4);
      check("rd_strobe_clks", n_rd, 2);
      check("rd_data", cpu_rdata_o[0], 8'h5A);

      // CPU write alone
      to_t4();
      cpu_req = 1; cpu_we = 1; cpu_addr = 16'hFF80; cpu_wdata = 8'h3C;
      n_wr = 0; n_rd = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (mem_wr_o[0]) n_wr++;
         if (mem_rd_o[0]) n_rd++;
         if (exp_ack(0, 2'd1)) cpu_req = 0;
      end
      check("wr_pulses", n_wr, 1);
      check("wr_no_rd", n_rd, 0);
      check("wr_data", mem_wdata_o[0], 8'h3C);

      // Contention: both requesting for 10 M-cycles
      to_t4();
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'hC100;
      dma_req = 1; dma_we = 0; dma_addr = 16'hFE00;
      n_cack = 0; n_dack = 0;
      for (int m = 0; m < 10; m++) begin
         for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 0) check($sformatf("contend_owner_%0d", m), owner_o[0], exp_seq[m]);
            if (cpu_ack_o[1]) n_cack++;
            if (dma_ack_o[1]) n_dack++;
         end
      end
      cpu_req = 0; dma_req = 0;
      check("strict_dma_acks", n_dack, 10);
      check("strict_cpu_acks", n_cack, 0);

      // Address change after grant must not reach the bus
      to_t4();
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h8000;
      tick();
      tick();
      cpu_addr = 16'h9000;
      tick();
      tick();
      check("hold_addr_t4", mem_addr_o[0], 16'h8000);
      cpu_req = 0;
      tick();
      check("hold_addr_none", mem_addr_o[0], 16'h8000);

      // Request withdrawn before the T4 edge
      cpu_req = 1; cpu_addr = 16'h1234;
      tick();
      tick();
      cpu_req = 0;
      tick();
      tick();
      check("withdraw_owner", owner_o[0], 2'd0);
      repeat (3) tick();

      // Reset in T3 of a read
      to_t4();
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h4000; mem_rdata = 8'hA5;
      repeat (3) tick();
      rst = 1'b0;
      model_reset();
      #1;
      check("rst_mem_rd", mem_rd_o[0], 1'b0);
      check("rst_owner", owner_o[0], 2'd0);
      check("rst_t_cycle", t_cycle_o[0], 2'd0);
      check("rst_cpu_ack", cpu_ack_o[0], 1'b0);
      @(posedge clk);
      @(negedge clk);
      check_dut(0);
      check_dut(1);
      rst = 1'b1;
      got = 0;
      for (int k = 0; k < 16 && !got; k++) begin
         tick();
         if (cpu_ack_o[0]) got = 1;
      end
      check("rerq_ack", got, 1'b1);
      check("rerq_data", cpu_rdata_o[0], 8'hA5);
      cpu_req = 0;

      // Randomized traffic
      for (int k = 0; k < 800; k++) begin
         tick();
         mem_rdata = 8'($urandom);
         if (cpu_req) begin
            if ((exp_ack(0, 2'd1) || exp_ack(1, 2'd1)) && $urandom_range(3) != 0) cpu_req = 0;
            else if ($urandom_range(15) == 0) cpu_req = 0;
            else if ($urandom_range(7) == 0) begin
               cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom);
            end
         end else if ($urandom_range(2) == 0) begin
            cpu_req = 1; cpu_we = 1'($urandom);
            cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom);
         end
         if (dma_req) begin
            if ((exp_ack(0, 2'd2) || exp_ack(1, 2'd2)) && $urandom_range(3) != 0) dma_req = 0;
            else if ($urandom_range(15) == 0) dma_req = 0;
            else if ($urandom_range(7) == 0) begin
               dma_addr = 16'($urandom); dma_wdata = 8'($urandom);
            end
         end else if ($urandom_range(2) == 0) begin
            dma_req = 1; dma_we = 1'($urandom);
            dma_addr = 16'($urandom); dma_wdata = 8'($urandom);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
